// File: rtl/multi_digit_calculator.sv
// Keyboard calculator core: DIGITS-digit BCD operands, add/subtract/multiply, shift-add multiplier
// and double-dabble result conversion. Optional result chaining via MULTI_DIGIT_CALC_CHAIN_EN.
module multi_digit_calculator #(
  parameter int DIGITS = 2
) (
  input  logic                  fcrystal,
  input  logic                  rst_n,
  input  logic                  key_valid,
  input  logic [3:0]            number,
  input  logic                  add,
  input  logic                  subtract,
  input  logic                  multiply,
  input  logic                  enter,
  input  logic                  clear,
  output logic [8*DIGITS-1:0]   disp,
  output logic                  neg,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            state
);
  localparam int IN_W  = $clog2(10**DIGITS);
  localparam int RES_W = $clog2(10**(2*DIGITS));
  localparam int BW    = 4*DIGITS;
  localparam int DW    = 8*DIGITS;
  localparam int CW    = $clog2(RES_W+1);
  localparam int NW    = $clog2(DIGITS+1);

  typedef enum logic [2:0] {
    ENTER_A = 3'd0, ENTER_B = 3'd1, CALC = 3'd2, CONV = 3'd3, SHOW = 3'd4
  } state_t;
  typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2} op_t;

  state_t            st;
  op_t               op;
  logic [BW-1:0]     a, b;
  logic [NW-1:0]     a_cnt, b_cnt;
  logic [RES_W-1:0]  mcand, res, sh;
  logic [IN_W-1:0]   mplier;
  logic [DW-1:0]     bcd;
  logic [CW-1:0]     cnt;
  logic              neg_pend;

  function automatic logic [IN_W-1:0] bcd2bin(input logic [BW-1:0] v);
    logic [IN_W-1:0] acc;
    acc = '0;
    for (int i = DIGITS-1; i >= 0; i--)
      acc = acc * IN_W'(4'd10) + IN_W'(v[4*i +: 4]);
    return acc;
  endfunction

  function automatic logic [DW-1:0] dd_adjust(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    r = v;
    for (int i = 0; i < 2*DIGITS; i++)
      r[4*i +: 4] = (v[4*i +: 4] >= 4'd5) ? v[4*i +: 4] + 4'd3 : v[4*i +: 4];
    return r;
  endfunction

  logic              k_clear, k_enter, k_op, k_digit;
  op_t               k_opcode;
  logic [IN_W-1:0]   a_v, b_v;
  logic [RES_W-1:0]  res_addsub, res_next;
  logic [DW-1:0]     bcd_next;
  logic [BW-1:0]     a_shift, b_shift;

  // Key decode with clear > enter > operator > digit, and operator ranking mul > sub > add
  always_comb begin
    k_clear = key_valid & clear;
    k_enter = key_valid & ~clear & enter;
    k_op    = key_valid & ~clear & ~enter & (add | subtract | multiply);
    k_digit = key_valid & ~clear & ~enter & ~(add | subtract | multiply) & (number <= 4'd9);
    if (multiply)
      k_opcode = OP_MUL;
    else if (subtract)
      k_opcode = OP_SUB;
    else
      k_opcode = OP_ADD;
  end

  // Datapath helpers: operand conversion, add/sub result, multiplier step, double-dabble step
  always_comb begin
    a_v = bcd2bin(a);
    b_v = bcd2bin(b);
    a_shift = (a << 3'd4) | BW'(number);
    b_shift = (b << 3'd4) | BW'(number);
    if (op == OP_ADD)
      res_addsub = RES_W'(a_v) + RES_W'(b_v);
    else if (a_v >= b_v)
      res_addsub = RES_W'(a_v - b_v);
    else
      res_addsub = RES_W'(b_v - a_v);
    if (mplier[0])
      res_next = res + mcand;
    else
      res_next = res;
    bcd_next = (dd_adjust(bcd) << 1'b1) | DW'(sh[RES_W-1]);
  end

  assign state = st;

  // Calculator FSM and datapath registers
  always_ff @(posedge fcrystal or negedge rst_n) begin
    if (!rst_n) begin
      st <= ENTER_A;   op <= OP_ADD;
      a <= '0;         b <= '0;       a_cnt <= '0;  b_cnt <= '0;
      mcand <= '0;     mplier <= '0;  res <= '0;    sh <= '0;
      bcd <= '0;       cnt <= '0;     neg_pend <= 1'b0;
      disp <= '0;      neg <= 1'b0;   busy <= 1'b0; done <= 1'b0;
    end else if (k_clear) begin
      st <= ENTER_A;   op <= OP_ADD;
      a <= '0;         b <= '0;       a_cnt <= '0;  b_cnt <= '0;
      mcand <= '0;     mplier <= '0;  res <= '0;    sh <= '0;
      bcd <= '0;       cnt <= '0;     neg_pend <= 1'b0;
      disp <= '0;      neg <= 1'b0;   busy <= 1'b0; done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (st)
        ENTER_A: begin
          if (k_op) begin
            op <= k_opcode; b <= '0; b_cnt <= '0; disp <= '0; st <= ENTER_B;
          end else if (k_digit && (a_cnt < NW'(DIGITS))) begin
            a <= a_shift; a_cnt <= a_cnt + 1'b1; disp <= DW'(a_shift);
          end
        end
        ENTER_B: begin
          if (k_enter) begin
            mcand <= RES_W'(a_v); mplier <= b_v; res <= '0; cnt <= '0;
            busy <= 1'b1; st <= CALC;
          end else if (k_op) begin
            op <= k_opcode;
          end else if (k_digit && (b_cnt < NW'(DIGITS))) begin
            b <= b_shift; b_cnt <= b_cnt + 1'b1; disp <= DW'(b_shift);
          end
        end
        CALC: begin
          if (op == OP_MUL) begin
            res    <= res_next;
            mcand  <= mcand << 1'b1;
            mplier <= mplier >> 1'b1;
            cnt    <= cnt + 1'b1;
            neg_pend <= 1'b0;
            if (cnt == CW'(IN_W-1)) begin
              sh <= res_next; bcd <= '0; cnt <= '0; st <= CONV;
            end
          end else begin
            res <= res_addsub; sh <= res_addsub; bcd <= '0; cnt <= '0;
            neg_pend <= (op == OP_SUB) && (a_v < b_v);
            st <= CONV;
          end
        end
        CONV: begin
          // disp keeps the old value until the last shift lands
          bcd <= bcd_next;
          sh  <= sh << 1'b1;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(RES_W-1)) begin
            disp <= bcd_next; neg <= neg_pend; busy <= 1'b0; done <= 1'b1; st <= SHOW;
          end
        end
        SHOW: begin
`ifdef MULTI_DIGIT_CALC_CHAIN_EN
          if (k_op && !neg && (res < RES_W'(10**DIGITS))) begin
            a <= disp[BW-1:0]; a_cnt <= NW'(DIGITS); op <= k_opcode;
            b <= '0; b_cnt <= '0; disp <= '0; st <= ENTER_B;
          end else if (k_digit) begin
            a <= BW'(number); a_cnt <= NW'(1); b <= '0; b_cnt <= '0;
            neg <= 1'b0; disp <= DW'(number); st <= ENTER_A;
          end
`else
          if (k_digit) begin
            a <= BW'(number); a_cnt <= NW'(1); b <= '0; b_cnt <= '0;
            neg <= 1'b0; disp <= DW'(number); st <= ENTER_A;
          end
`endif
        end
        default: begin
          st <= ENTER_A; busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_multi_digit_calculator.sv
// Self-checking bench for multi_digit_calculator (DIGITS=2): vector table, random
// operations against an arithmetic reference, and hand-written corner sequences.
module tb_multi_digit_calculator;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        key_valid = 1'b0, add = 1'b0, subtract = 1'b0, multiply = 1'b0;
  logic        enter = 1'b0, clear = 1'b0;
  logic [3:0]  number = 4'hF;
  logic [15:0] disp;
  logic        neg, busy, done;
  logic [2:0]  state;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multi_digit_calculator #(.DIGITS(2)) dut (
    .fcrystal(clk), .rst_n(rst_n), .key_valid(key_valid), .number(number),
    .add(add), .subtract(subtract), .multiply(multiply), .enter(enter), .clear(clear),
    .disp(disp), .neg(neg), .busy(busy), .done(done), .state(state)
  );

  typedef struct {
    int          a;
    int          b;
    int          opc;
    logic [15:0] exp_disp;
    logic        exp_neg;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] num, input logic a_k, input logic s_k,
                       input logic m_k, input logic e_k, input logic c_k);
    @(negedge clk);
    key_valid = 1'b1; number = num; add = a_k; subtract = s_k;
    multiply = m_k; enter = e_k; clear = c_k;
    @(negedge clk);
    key_valid = 1'b0; number = 4'hF; add = 1'b0; subtract = 1'b0;
    multiply = 1'b0; enter = 1'b0; clear = 1'b0;
  endtask

  // k: 0..9 digit, 10 '+', 11 '-', 12 '*', 13 '=', 14 clear
  task automatic key(input int k);
    if (k <= 9)
      press(4'(k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    else
      press(4'hF, k == 10, k == 11, k == 12, k == 13, k == 14);
  endtask

  task automatic type_num(input int v);
    if (v >= 10) key(v / 10);
    key(v % 10);
  endtask

  task automatic wait_done(output int lat, output int busy_n, output logic got);
    lat = 0; busy_n = 0; got = 1'b0;
    while (lat < 60 && !got) begin
      @(posedge clk); #1;
      lat++;
      if (done) got = 1'b1;
      else if (busy) busy_n++;
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    r = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int model_res(input int a, input int b, input int opc);
    if (opc == 10) return a + b;
    if (opc == 11) return (a >= b) ? a - b : b - a;
    return a * b;
  endfunction

  task automatic run_calc(input string tag, input int a, input int b, input int opc,
                          input logic [15:0] exp_disp, input logic exp_neg, input int exp_lat);
    int lat, busy_n;
    logic got;
    key(14);
    type_num(a);
    check({tag, " entryA"}, disp, to_bcd(a));
    key(opc);
    check({tag, " stateB"}, state, 3'd1);
    type_num(b);
    key(13);
    wait_done(lat, busy_n, got);
    check({tag, " done"}, got, 1'b1);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busycycles"}, busy_n, exp_lat - 1);
    check({tag, " disp"}, disp, exp_disp);
    check({tag, " neg"}, neg, exp_neg);
    check({tag, " show"}, state, 3'd4);
  endtask

  initial begin
    int lat, busy_n, a, b, opc, r, seen;
    logic got;

    vecs[0] = '{47, 58, 10, 16'h0105, 1'b0, 15};
    vecs[1] = '{12, 34, 11, 16'h0022, 1'b1, 15};
    vecs[2] = '{99, 99, 12, 16'h9801, 1'b0, 21};
    vecs[3] = '{0,  0,  10, 16'h0000, 1'b0, 15};
    vecs[4] = '{99, 99, 10, 16'h0198, 1'b0, 15};
    vecs[5] = '{34, 12, 11, 16'h0022, 1'b0, 15};
    vecs[6] = '{5,  7,  12, 16'h0035, 1'b0, 21};
    vecs[7] = '{0,  99, 12, 16'h0000, 1'b0, 21};
    vecs[8] = '{99, 99, 11, 16'h0000, 1'b0, 15};
    vecs[9] = '{7,  8,  12, 16'h0056, 1'b0, 21};

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset disp", disp, 16'h0000);
    check("reset neg", neg, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset state", state, 3'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      run_calc($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].opc,
               vecs[i].exp_disp, vecs[i].exp_neg, vecs[i].exp_lat);

    for (int i = 0; i < 24; i++) begin
      a = int'($urandom_range(0, 99));
      b = int'($urandom_range(0, 99));
      opc = 10 + int'($urandom_range(0, 2));
      r = model_res(a, b, opc);
      run_calc($sformatf("rnd%0d", i), a, b, opc, to_bcd(r),
               (opc == 11) && (a < b), (opc == 12) ? 21 : 15);
    end

    // 12-34 then a digit restarts entry
    run_calc("sub_then_digit", 12, 34, 11, 16'h0022, 1'b1, 15);
    key(5);
    check("digit_from_show state", state, 3'd0);
    check("digit_from_show disp", disp, 16'h0005);
    check("digit_from_show neg", neg, 1'b0);

    // Third digit and unqualified keys ignored; enter ignored in ENTER_A
    key(14); key(1); key(2); key(3);
    check("three_digits disp", disp, 16'h0012);
    @(negedge clk); number = 4'd9; add = 1'b1;
    @(negedge clk); number = 4'hF; add = 1'b0;
    check("no_valid disp", disp, 16'h0012);
    check("no_valid state", state, 3'd0);
    key(13);
    check("enter_in_A state", state, 3'd0);

    // Priority: mul over add over digit, then enter over digit
    key(14); key(6);
    press(4'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("prio op state", state, 3'd1);
    check("prio op disp", disp, 16'h0000);
    key(7);
    press(4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_done(lat, busy_n, got);
    check("prio done", got, 1'b1);
    check("prio mul disp", disp, 16'h0042);
    check("prio latency", lat, 21);

    // Operator in SHOW with result >= 100 is ignored in either build
    run_calc("show_op", 47, 58, 10, 16'h0105, 1'b0, 15);
    key(10);
    check("show_op state", state, 3'd4);
    check("show_op disp", disp, 16'h0105);

    // Chaining a small result
    run_calc("chain_base", 12, 3, 10, 16'h0015, 1'b0, 15);
    key(12); key(2); key(13);
`ifdef MULTI_DIGIT_CALC_CHAIN_EN
    wait_done(lat, busy_n, got);
    check("chain done", got, 1'b1);
    check("chain disp", disp, 16'h0030);
`else
    check("nochain state", state, 3'd0);
    check("nochain disp", disp, 16'h0002);
`endif

    // Clear during CONV discards the operation
    key(14); key(1); key(2); key(12); key(3); key(4); key(13);
    repeat (10) @(negedge clk);
    check("mid_conv busy", busy, 1'b1);
    key(14);
    check("clear state", state, 3'd0);
    check("clear disp", disp, 16'h0000);
    check("clear busy", busy, 1'b0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("clear no_done", seen, 0);

    // Asynchronous reset in the middle of a calculation
    key(14); key(4); key(7); key(10); key(5); key(8); key(13);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst disp", disp, 16'h0000);
    check("async_rst neg", neg, 1'b0);
    check("async_rst busy", busy, 1'b0);
    check("async_rst state", state, 3'd0);
    @(negedge clk); rst_n = 1'b1;
    run_calc("after_rst", 9, 9, 12, 16'h0081, 1'b0, 21);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
